// File: rtl/pcs_10g_block_sync_pkg.sv
// Shared 10G PCS receive-path definitions: 64b/66b sync header encodings,
// block-sync FSM state encoding and default block-lock window sizes.
package pcs_10g_block_sync_pkg;

   // The two legal 66b sync headers; 2'b00 and 2'b11 never occur on a good link.
   localparam logic [1:0] SYNC_HEAD_DATA = 2'b01;
   localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;

   // Default block-lock window: headers per window, invalid headers that force
   // a slip while locked, and valid blocks skipped while the gearbox realigns.
   localparam int DEFAULT_SH_CNT_MAX = 64;
   localparam int DEFAULT_SH_INV_MAX = 16;
   localparam int DEFAULT_SLIP_WAIT  = 4;

   // Block-lock state machine states.
   typedef enum logic [2:0] {
      ST_LOCK_INIT = 3'd0,
      ST_RESET_CNT = 3'd1,
      ST_TEST_SH   = 3'd2,
      ST_SLIP      = 3'd3,
      ST_SLIP_WAIT = 3'd4
   } block_sync_state_t;

   // A sync header is good when exactly one of its two bits is set.
   function automatic logic is_valid_header(input logic [1:0] hdr);
      return (hdr == SYNC_HEAD_DATA) || (hdr == SYNC_HEAD_CTRL);
   endfunction

endpackage

// File: rtl/pcs_10g_block_sync.sv
// 10GBASE-R block synchroniser. Sits between the 64b/66b gearbox and the
// descrambler: watches the 2-bit sync headers the gearbox presents, asks the
// gearbox to slip one bit until headers line up, and reports block lock.
module pcs_10g_block_sync
   import pcs_10g_block_sync_pkg::*;
#(
   parameter int SH_CNT_MAX = DEFAULT_SH_CNT_MAX,
   parameter int SH_INV_MAX = DEFAULT_SH_INV_MAX,
   parameter int SLIP_WAIT  = DEFAULT_SLIP_WAIT
)(
   input  logic       rx_par_clk,
   input  logic       reset,
   input  logic       signal_ok_i,
   input  logic       valid_i,
   input  logic [1:0] sync_head_i,
   output logic       slip_o,
   output logic       block_lock_o
);

   localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
   localparam int INV_W  = $clog2(SH_INV_MAX + 1);
   localparam int WAIT_W = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);

   localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(SH_CNT_MAX);
   localparam logic [INV_W-1:0]  INV_LIMIT  = INV_W'(SH_INV_MAX);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(SLIP_WAIT);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [INV_W-1:0]  INV_ONE    = INV_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

   block_sync_state_t state;
   logic [CNT_W-1:0]  sh_cnt;
   logic [INV_W-1:0]  sh_inv_cnt;
   logic [WAIT_W-1:0] wait_cnt;

   logic              hdr_bad;
   logic [CNT_W-1:0]  cnt_base;
   logic [INV_W-1:0]  inv_base;
   logic [CNT_W-1:0]  cnt_inc;
   logic [INV_W-1:0]  inv_inc;
   logic [WAIT_W-1:0] wait_inc;
   logic              slip_needed;
   logic              window_done;

   // Window arithmetic for the header presented this cycle. RESET_CNT starts
   // from an empty window, so a header arriving in that cycle is counted as
   // the first of the new window instead of being lost. Counters saturate.
   always_comb begin
      hdr_bad     = !is_valid_header(sync_head_i);
      cnt_base    = (state == ST_RESET_CNT) ? '0 : sh_cnt;
      inv_base    = (state == ST_RESET_CNT) ? '0 : sh_inv_cnt;
      cnt_inc     = (cnt_base == CNT_LIMIT) ? cnt_base : cnt_base + CNT_ONE;
      inv_inc     = (hdr_bad && (inv_base != INV_LIMIT)) ? inv_base + INV_ONE : inv_base;
      wait_inc    = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + WAIT_ONE;
      // Unlocked: one bad header is enough. Locked: slip once the window has
      // collected SH_INV_MAX bad headers, even if this is also the last header.
      slip_needed = (hdr_bad && !block_lock_o) ||
                    (block_lock_o && (inv_inc == INV_LIMIT));
      window_done = (cnt_inc == CNT_LIMIT);
   end

   // Block-lock FSM with registered slip and lock outputs.
   always_ff @(posedge rx_par_clk or posedge reset) begin
      if (reset) begin
         state        <= ST_LOCK_INIT;
         sh_cnt       <= '0;
         sh_inv_cnt   <= '0;
         wait_cnt     <= '0;
         slip_o       <= 1'b0;
         block_lock_o <= 1'b0;
      end else if (!signal_ok_i) begin
         // Loss of SerDes lock restarts the whole search.
         state        <= ST_LOCK_INIT;
         sh_cnt       <= '0;
         sh_inv_cnt   <= '0;
         wait_cnt     <= '0;
         slip_o       <= 1'b0;
         block_lock_o <= 1'b0;
      end else begin
         slip_o <= 1'b0;
         case (state)
            ST_LOCK_INIT: begin
               block_lock_o <= 1'b0;
               sh_cnt       <= '0;
               sh_inv_cnt   <= '0;
               state        <= ST_RESET_CNT;
            end

            ST_RESET_CNT, ST_TEST_SH: begin
               if (!valid_i) begin
                  // No header this cycle: hold the window as it stands.
                  sh_cnt     <= cnt_base;
                  sh_inv_cnt <= inv_base;
                  state      <= ST_TEST_SH;
               end else if (slip_needed) begin
                  block_lock_o <= 1'b0;
                  slip_o       <= 1'b1;
                  sh_cnt       <= '0;
                  sh_inv_cnt   <= '0;
                  state        <= ST_SLIP;
               end else if (window_done) begin
                  // A clean window grants lock; a window with a tolerated
                  // number of errors leaves the lock state as it was.
                  if (inv_inc == '0) begin
                     block_lock_o <= 1'b1;
                  end
                  sh_cnt     <= '0;
                  sh_inv_cnt <= '0;
                  state      <= ST_RESET_CNT;
               end else begin
                  sh_cnt     <= cnt_inc;
                  sh_inv_cnt <= inv_inc;
                  state      <= ST_TEST_SH;
               end
            end

            ST_SLIP: begin
               // The slip pulse is being presented this cycle; start the
               // realignment hold-off so the next slip cannot follow closely.
               wait_cnt <= '0;
               if (SLIP_WAIT == 0) begin
                  state <= ST_RESET_CNT;
               end else begin
                  state <= ST_SLIP_WAIT;
               end
            end

            ST_SLIP_WAIT: begin
               // Blocks here are still shifting through the gearbox; count
               // them without judging their headers.
               if (valid_i) begin
                  if (wait_inc == WAIT_LIMIT) begin
                     wait_cnt <= '0;
                     state    <= ST_RESET_CNT;
                  end else begin
                     wait_cnt <= wait_inc;
                  end
               end
            end

            default: begin
               state <= ST_LOCK_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pcs_10g_block_sync.sv
// Bench for pcs_10g_block_sync: directed block-lock scenarios followed by
// randomized header streams, checked per cycle against a header-stream model.
module tb_pcs_10g_block_sync;

   localparam int CNT_MAX = 64;
   localparam int INV_MAX = 16;
   localparam int WAIT_N  = 4;

   logic       rx_par_clk  = 1'b0;
   logic       reset       = 1'b0;
   logic       signal_ok_i = 1'b0;
   logic       valid_i     = 1'b0;
   logic [1:0] sync_head_i = 2'b01;
   logic       slip_o;
   logic       block_lock_o;

   pcs_10g_block_sync #(
      .SH_CNT_MAX (CNT_MAX),
      .SH_INV_MAX (INV_MAX),
      .SLIP_WAIT  (WAIT_N)
   ) dut (
      .rx_par_clk   (rx_par_clk),
      .reset        (reset),
      .signal_ok_i  (signal_ok_i),
      .valid_i      (valid_i),
      .sync_head_i  (sync_head_i),
      .slip_o       (slip_o),
      .block_lock_o (block_lock_o)
   );

   always #5 rx_par_clk = ~rx_par_clk;

   typedef struct packed {
      logic slip;
      logic lock;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   // Reference model of the header stream:
   //   m_lock  - link considered locked
   //   m_seen  - headers judged in the current window, m_bad of them invalid
   //   m_blind - whole cycles to ignore (restart after reset / signal loss,
   //             and the cycle in which the slip request is presented)
   //   m_skip  - further valid blocks to discard after a slip
   bit m_lock  = 1'b0;
   bit m_slip  = 1'b0;
   int m_seen  = 0;
   int m_bad   = 0;
   int m_blind = 1;
   int m_skip  = 0;

   function automatic logic [1:0] good_hdr();
      return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] bad_hdr();
      return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
   endfunction

   task automatic model_cycle(input bit r, input bit sok, input bit v, input logic [1:0] h);
      bit bad;
      bad    = !(h == 2'b01 || h == 2'b10);
      m_slip = 1'b0;
      if (r || !sok) begin
         m_lock  = 1'b0;
         m_seen  = 0;
         m_bad   = 0;
         m_skip  = 0;
         m_blind = 1;
      end else if (m_blind > 0) begin
         m_blind--;
      end else if (m_skip > 0) begin
         if (v) m_skip--;
      end else if (v) begin
         m_seen++;
         if (bad) m_bad++;
         if ((bad && !m_lock) || (m_lock && m_bad >= INV_MAX)) begin
            m_slip  = 1'b1;
            m_lock  = 1'b0;
            m_seen  = 0;
            m_bad   = 0;
            m_blind = 1;
            m_skip  = WAIT_N;
         end else if (m_seen >= CNT_MAX) begin
            if (m_bad == 0) m_lock = 1'b1;
            m_seen = 0;
            m_bad  = 0;
         end
      end
   endtask

   // One clock of stimulus: drive inputs, queue the expected post-edge outputs.
   task automatic step(input bit r, input bit sok, input bit v, input logic [1:0] h);
      exp_t e;
      reset       = r;
      signal_ok_i = sok;
      valid_i     = v;
      sync_head_i = h;
      model_cycle(r, sok, v, h);
      e.slip = m_slip;
      e.lock = m_lock;
      exp_q.push_back(e);
      @(posedge rx_par_clk);
      #1;
   endtask

   // n headers numbered 1..n, those in [bad_from, bad_to] invalid.
   task automatic send(input int n, input int bad_from, input int bad_to);
      for (int i = 1; i <= n; i++) begin
         step(1'b0, 1'b1, 1'b1, (i >= bad_from && i <= bad_to) ? bad_hdr() : good_hdr());
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, bad_hdr());
   endtask

   // Assert reset between edges and confirm the outputs drop without a clock.
   task automatic pulse_reset_async();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (slip_o !== 1'b0 || block_lock_o !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got slip=%0b lock=%0b, expected slip=0 lock=0",
                  slip_o, block_lock_o);
      end
      step(1'b1, 1'b0, 1'b0, 2'b01);
      step(1'b1, 1'b1, 1'b1, 2'b01);
   endtask

   // Monitor: every clock the DUT presents its outputs; pop and compare.
   int valid_since = 1000;
   bit prev_slip   = 1'b0;
   initial begin : monitor
      exp_t e;
      bit   v_edge;
      bit   clr_edge;
      forever begin
         @(posedge rx_par_clk);
         v_edge   = valid_i && signal_ok_i && !reset;
         clr_edge = reset || !signal_ok_i;
         #2;
         cycle++;
         if (clr_edge) valid_since = 1000;
         else if (v_edge) valid_since++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (slip_o !== e.slip || block_lock_o !== e.lock) begin
               errors++;
               $display("FAIL scoreboard cycle %0d: got slip=%0b lock=%0b, expected slip=%0b lock=%0b",
                        cycle, slip_o, block_lock_o, e.slip, e.lock);
            end else if (e.slip || (e.lock != m_lock)) begin
               $display("cycle %0d: slip=%0b lock=%0b", cycle, slip_o, block_lock_o);
            end
         end
         if (slip_o === 1'b1) begin
            checks++;
            if (prev_slip || valid_since < WAIT_N) begin
               errors++;
               $display("FAIL slip_spacing cycle %0d: got %0d valid blocks since last slip, expected at least %0d",
                        cycle, valid_since, WAIT_N);
            end
            valid_since = 0;
         end
         prev_slip = (slip_o === 1'b1);
      end
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: got no finish, expected finish within 5ms");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      int bad_pct;
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (slip_o !== 1'b0 || block_lock_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got slip=%0b lock=%0b, expected slip=0 lock=0",
                  slip_o, block_lock_o);
      end
      repeat (3) step(1'b1, 1'b0, 1'b0, 2'b01);

      // Initial lock: 63 good headers do not lock, the 64th does.
      idle(1);
      send(63, 0, -1);
      send(1, 0, -1);
      idle(2);

      // Locked: 15 bad in a window holds lock; 16th bad on the 64th header slips.
      send(64, 1, 15);
      send(64, 49, 64);
      send(1 + WAIT_N, 0, -1);

      // Unlocked: bad header at block 10 slips, next blocks skipped, then relock.
      send(10, 10, 10);
      send(1 + WAIT_N, 0, -1);
      send(64, 0, -1);
      idle(2);

      // Signal loss for one cycle while locked, then relock.
      step(1'b0, 1'b0, 1'b1, good_hdr());
      send(1 + 64, 0, -1);
      idle(2);

      // Reset mid-window, then lock with valid_i low every other cycle.
      send(30, 0, -1);
      pulse_reset_async();
      idle(1);
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 1'b1, 1'b1, good_hdr());
         step(1'b0, 1'b1, 1'b0, bad_hdr());
      end
      idle(2);

      // Randomized streams with a varying header error rate.
      bad_pct = 0;
      for (int i = 0; i < 6000; i++) begin
         if (i % 400 == 0) begin
            case ($urandom_range(0, 3))
               0:       bad_pct = 0;
               1:       bad_pct = 1;
               2:       bad_pct = 10;
               default: bad_pct = 40;
            endcase
         end
         if ($urandom_range(0, 1999) == 0) begin
            pulse_reset_async();
         end else begin
            step(1'b0,
                 $urandom_range(0, 299) != 0,
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 99) < bad_pct) ? bad_hdr() : good_hdr());
         end
      end

      idle(1);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcs_10g_block_sync.md
PCS_10G_BLOCK_SYNC -- requirements
Module: pcs_10g_block_sync

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64, meaning sync headers per test window.
REQ-002 SHALL have parameter SH_INV_MAX, default 16, meaning invalid headers per window that force a slip while locked.
REQ-003 SHALL have parameter SLIP_WAIT, default 4, meaning valid blocks ignored after a slip while the gearbox realigns.
REQ-004 SHALL have port rx_par_clk  in  1  the single clock; all logic in this domain.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port signal_ok_i  in  1  SerDes receiver lock; low forces loss of block lock.
REQ-007 SHALL have port valid_i  in  1  the gearbox presents a block header this cycle.
REQ-008 SHALL have port sync_head_i  in  2  the 66-bit block's 2-bit sync header, qualified by valid_i.
REQ-009 SHALL have port slip_o  out  1  one-cycle pulse requesting a one-bit gearbox slip.
REQ-010 SHALL have port block_lock_o  out  1  block lock achieved; consumed by descrambler and decoder.

Function
REQ-011 SHALL treat header 2'b01 or 2'b10 as valid and 2'b00 or 2'b11 as invalid.
REQ-012 SHALL implement FSM states LOCK_INIT, RESET_CNT, TEST_SH, SLIP, SLIP_WAIT.
REQ-013 SHALL go LOCK_INIT -> RESET_CNT unconditionally; clear block_lock; RESET_CNT clears sh_cnt and sh_inv_cnt, then -> TEST_SH.
REQ-014 SHALL in TEST_SH, on each valid_i=1 cycle, increment sh_cnt and increment sh_inv_cnt when the header is invalid; valid_i=0 cycles change nothing.
REQ-015 SHALL, when sh_cnt reaches SH_CNT_MAX with sh_inv_cnt=0, set block_lock and go to RESET_CNT.
REQ-016 SHALL, when sh_cnt reaches SH_CNT_MAX with 0 < sh_inv_cnt < SH_INV_MAX while locked, keep lock and go to RESET_CNT.
REQ-017 SHALL go to SLIP on any invalid header while unlocked, or when sh_inv_cnt reaches SH_INV_MAX while locked; the same-cycle case (64th header is the 16th invalid) SHALL slip.
REQ-018 SHALL in SLIP clear block_lock, pulse slip_o for exactly one cycle, then go to SLIP_WAIT.
REQ-019 SHALL in SLIP_WAIT count SLIP_WAIT valid blocks without checking them, then go to RESET_CNT.
REQ-020 SHALL size sh_cnt at clog2(SH_CNT_MAX+1) and sh_inv_cnt at clog2(SH_INV_MAX+1) bits, saturating, never wrapping.
REQ-021 SHALL register block_lock_o and slip_o; each changes on the clock edge that makes the deciding FSM transition, with no combinational path from inputs.
REQ-022 SHALL have signal_ok_i=0 override all states: next state LOCK_INIT, block_lock_o low on the next edge, slip_o low, and counters cleared.
REQ-023 SHALL never assert slip_o in two consecutive cycles, nor before SLIP_WAIT valid blocks have elapsed since the previous pulse.

Reset
REQ-024 SHALL on reset asynchronously force state LOCK_INIT, sh_cnt=0, sh_inv_cnt=0, slip_o=0, block_lock_o=0.
REQ-025 SHALL resume from LOCK_INIT on the first rx_par_clk edge after reset deasserts, including reset asserted mid-window or mid-SLIP_WAIT.

Structure
REQ-026 SHALL take header encodings (SYNC_HEAD_DATA=2'b01, SYNC_HEAD_CTRL=2'b10), the FSM state enum and default window constants from the shared pcs package.
REQ-027 SHALL be a single module with no sub-module; it sits between the 64b/66b gearbox and the descrambler in the 10G receive path.

Verification
REQ-028 SHALL cover: reset, signal_ok_i=1, 63 valid 2'b01 headers -> block_lock_o=0; 64th -> block_lock_o=1 on the following cycle.
REQ-029 SHALL cover: unlocked, header 2'b00 at block 10 -> single slip_o pulse; next 4 valid blocks ignored; lock after 64 further good headers.
REQ-030 SHALL cover: locked, 15 invalid in a 64-header window -> lock held; 16 invalid within a window -> block_lock_o=0 and one slip_o pulse.
REQ-031 SHALL cover: 64 good headers with valid_i low every other cycle -> lock only after the 64th valid cycle (128 clocks).
REQ-032 SHALL cover: locked, signal_ok_i dropped for 1 cycle -> block_lock_o=0 next cycle, relock after 64 good headers; reset pulsed mid-window -> outputs 0 immediately.
